reg_share_arbiter: RTL



---
 rtl/reg_share_pkg.sv | 9 +
 rtl/rr_priority_picker.sv | 32 +++
 rtl/reg_share_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/reg_share_pkg.sv
// Shared types and widths for the round-robin register-sharing arbiter.
package reg_share_pkg;

    typedef enum logic {IDLE, HOLD} reg_share_state_t;

    localparam int REG_SHARE_CNT_W  = 16;
    localparam int REG_SHARE_HOLD_W = 8;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_priority_picker #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any_grant,
    output logic [IDX_W-1:0] winner
);

    logic [N_REQ-1:0]   mask;
    logic [2*N_REQ-1:0] dbl;

    // Lower half keeps only requests at/after ptr; upper half is the wrapped copy.
    always_comb begin
        mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            mask[i] = (IDX_W'(i) >= ptr);
        end
        dbl       = {req, req & mask};
        any_grant = 1'b0;
        winner    = '0;
        for (int i = 0; i < 2*N_REQ; i++) begin
            if (dbl[i] && !any_grant) begin
                any_grant = 1'b1;
                winner    = (i < N_REQ) ? IDX_W'(i) : IDX_W'(i - N_REQ);
            end
        end
    end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin sharing of one flop register among N_REQ requesters with a post-load hold.
// Optional load counter output load_cnt is enabled by defining REG_SHARE_CNT_EN.
module reg_share_arbiter
    import reg_share_pkg::*;
#(
    parameter  int N_REQ       = 4,
    parameter  int WIDTH       = 4,
    parameter  int HOLD_CYCLES = 1,
    localparam int IDX_W       = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] d,
    output logic [WIDTH-1:0]       q,
    output logic                   valid,
    output logic [IDX_W-1:0]       owner,
    output logic [N_REQ-1:0]       ack,
    output logic                   busy
`ifdef REG_SHARE_CNT_EN
    ,
    output logic [REG_SHARE_CNT_W-1:0] load_cnt
`endif
);

    localparam logic [REG_SHARE_HOLD_W-1:0] HOLD_INIT = REG_SHARE_HOLD_W'(HOLD_CYCLES);
    localparam logic [IDX_W-1:0]            LAST_IDX  = IDX_W'(N_REQ - 1);

    reg_share_state_t            state_q, state_d;
    logic [IDX_W-1:0]            ptr_q, ptr_d;
    logic [REG_SHARE_HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [WIDTH-1:0]            q_q, q_d;
    logic                        valid_q, valid_d;
    logic [IDX_W-1:0]            owner_q, owner_d;
    logic [N_REQ-1:0]            ack_q, ack_d;

    logic [N_REQ-1:0] req_masked;
    logic             pick_any;
    logic [IDX_W-1:0] pick_win;
    logic             grant;

    // A request being acked this cycle must not win again when there is no hold.
    assign req_masked = req & ~ack_q;

    rr_priority_picker #(
        .N_REQ(N_REQ)
    ) u_picker (
        .req      (req_masked),
        .ptr      (ptr_q),
        .any_grant(pick_any),
        .winner   (pick_win)
    );

    assign grant = (state_q == IDLE) && pick_any;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        q_d        = q_q;
        valid_d    = valid_q;
        owner_d    = owner_q;
        ack_d      = '0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    q_d        = d[pick_win*WIDTH +: WIDTH];
                    owner_d    = pick_win;
                    ack_d      = N_REQ'(1) << pick_win;
                    valid_d    = 1'b1;
                    ptr_d      = (pick_win == LAST_IDX) ? '0 : pick_win + IDX_W'(1);
                    hold_cnt_d = HOLD_INIT;
                    state_d    = (HOLD_CYCLES > 0) ? HOLD : IDLE;
                end
            end
            HOLD: begin
                hold_cnt_d = hold_cnt_q - REG_SHARE_HOLD_W'(1);
                if (hold_cnt_q <= REG_SHARE_HOLD_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            q_q        <= '0;
            valid_q    <= 1'b0;
            owner_q    <= '0;
            ack_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            q_q        <= q_d;
            valid_q    <= valid_d;
            owner_q    <= owner_d;
            ack_q      <= ack_d;
        end
    end

    assign q     = q_q;
    assign valid = valid_q;
    assign owner = owner_q;
    assign ack   = ack_q;
    assign busy  = (state_q == HOLD);

`ifdef REG_SHARE_CNT_EN
    logic [REG_SHARE_CNT_W-1:0] load_cnt_q, load_cnt_d;

    // Saturating count of grant edges.
    always_comb begin
        load_cnt_d = load_cnt_q;
        if (grant && (load_cnt_q != '1)) begin
            load_cnt_d = load_cnt_q + REG_SHARE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_cnt_q <= '0;
        end else begin
            load_cnt_q <= load_cnt_d;
        end
    end

    assign load_cnt = load_cnt_q;
`else
    logic unused_grant;
    assign unused_grant = grant;
`endif

endmodule
